buf_arbiter: RTL and testbench

BUF_ARBITER -- requirements
Module: buf_arbiter

---
 rtl/buf_arbiter_if.sv | 26 ++
 rtl/buf_arbiter.sv | 88 ++++++++
 tb/tb_buf_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/buf_arbiter_if.sv
// Write-side bus of buf_arbiter: two requesters, clear pulse and reduction results.
// One-cycle grants, no valid/ready: a requester holds reqN level with wdataN stable until it samples gntN high.
interface buf_arbiter_if #(parameter int DATA_W = 4);
    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              clr;
    logic              gnt0;
    logic              gnt1;
    logic [1:0]        count;
    logic              busy;
    logic              res_valid;
    logic [DATA_W-1:0] and_res;
    logic [DATA_W-1:0] or_res;

    modport master (
        output req0, req1, wdata0, wdata1, clr,
        input  gnt0, gnt1, count, busy, res_valid, and_res, or_res
    );

    modport slave (
        input  req0, req1, wdata0, wdata1, clr,
        output gnt0, gnt1, count, busy, res_valid, and_res, or_res
    );
endinterface

// File: rtl/buf_arbiter.sv
// Round-robin arbiter filling a 3-slot buffer; once full, reduces the slots to
// registered AND/OR results and holds them until a clear.
module buf_arbiter #(
    parameter int DATA_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    buf_arbiter_if.slave bus,
    output logic [1:0]  o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_REDUCE, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_gnt_id;
    logic              r_last_id;
    logic              w_winner;
    logic [DATA_W-1:0] r_slot [3];
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_and;
    logic [DATA_W-1:0] r_or;
    logic [DATA_W-1:0] w_wdata;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        w_winner = 1'b0;
        if (bus.req0 && bus.req1) w_winner = ~r_last_id;
        else if (bus.req1)        w_winner = 1'b1;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.req0 || bus.req1) w_next = S_GRANT;
            S_GRANT:  w_next = (r_count == 2'd2) ? S_REDUCE : S_IDLE;
            S_REDUCE: w_next = S_DONE;
            S_DONE:   w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
        if (bus.clr) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    assign w_wdata = r_gnt_id ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_id  <= 1'b0;
            r_last_id <= 1'b1;
            r_wr_ptr  <= 2'd0;
            r_count   <= 2'd0;
            r_and     <= '0;
            r_or      <= '0;
            for (int i = 0; i < 3; i++) r_slot[i] <= '0;
        end else begin
            if (r_state == S_IDLE && w_next == S_GRANT) r_gnt_id <= w_winner;
            // last_id tracks the grant even when a clear discards its write.
            if (r_state == S_GRANT) r_last_id <= r_gnt_id;
            if (bus.clr) begin
                r_wr_ptr <= 2'd0;
                r_count  <= 2'd0;
                for (int i = 0; i < 3; i++) r_slot[i] <= '0;
            end else if (r_state == S_GRANT) begin
                r_slot[r_wr_ptr] <= w_wdata;
                r_wr_ptr         <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
                r_count          <= r_count + 2'd1;
            end
            if (r_state == S_REDUCE) begin
                r_and <= r_slot[0] & r_slot[1] & r_slot[2];
                r_or  <= r_slot[0] | r_slot[1] | r_slot[2];
            end
        end
    end

    assign bus.gnt0      = (r_state == S_GRANT) && !r_gnt_id;
    assign bus.gnt1      = (r_state == S_GRANT) &&  r_gnt_id;
    assign bus.busy      = (r_state == S_REDUCE) || (r_state == S_DONE);
    assign bus.res_valid = (r_state == S_DONE);
    assign bus.count     = r_count;
    assign bus.and_res   = r_and;
    assign bus.or_res    = r_or;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_buf_arbiter.sv
// Directed bench for buf_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_buf_arbiter;
  localparam int DATA_W = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  buf_arbiter_if #(.DATA_W(DATA_W)) bus ();

  buf_arbiter #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One write by requester id; expects a single-cycle grant one edge after the request.
  task automatic write_one(input int id, input logic [DATA_W-1:0] d);
    int lat;
    bit seen;
    if (id == 0) begin bus.req0 = 1'b1; bus.wdata0 = d; end
    else         begin bus.req1 = 1'b1; bus.wdata1 = d; end
    seen = 0;
    lat  = 0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if ((id == 0) ? bus.gnt0 : bus.gnt1) seen = 1;
    end
    check("gnt_seen", 32'(seen), 32'd1);
    check("gnt_latency", 32'(lat), 32'd1);
    check("gnt_other_low", 32'((id == 0) ? bus.gnt1 : bus.gnt0), 32'd0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    check("gnt_one_cycle", 32'((id == 0) ? bus.gnt0 : bus.gnt1), 32'd0);
  endtask

  logic exp_g0 [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic exp_g1 [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus.clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    // reset state
    check("rst_gnt0", 32'(bus.gnt0), 32'd0);
    check("rst_gnt1", 32'(bus.gnt1), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_and", 32'(bus.and_res), 32'd0);
    check("rst_or", 32'(bus.or_res), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // single write from requester 0
    write_one(0, 4'h5);
    check("w1_count", 32'(bus.count), 32'd1);
    check("w1_busy", 32'(bus.busy), 32'd0);

    // both requesting: grants alternate 0,1,0 with 2-cycle spacing, then reduce
    do_reset();
    bus.wdata0 = 4'h3;
    bus.wdata1 = 4'h1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rr_gnt0_%0d", i), 32'(bus.gnt0), 32'(exp_g0[i]));
      check($sformatf("rr_gnt1_%0d", i), 32'(bus.gnt1), 32'(exp_g1[i]));
      bus.req0 = !bus.gnt0;
      bus.req1 = !bus.gnt1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("rr_count", 32'(bus.count), 32'd3);
    check("rr_busy_reduce", 32'(bus.busy), 32'd1);
    check("rr_valid_reduce", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check("rr_valid", 32'(bus.res_valid), 32'd1);
    check("rr_and", 32'(bus.and_res), 32'h1);
    check("rr_or", 32'(bus.or_res), 32'h3);

    // clear, then fill with 0xF, 0x6, 0xE
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("clr1_count", 32'(bus.count), 32'd0);
    write_one(0, 4'hF);
    write_one(0, 4'h6);
    write_one(0, 4'hE);
    check("fill_count", 32'(bus.count), 32'd3);
    check("fill_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("fill_and", 32'(bus.and_res), 32'h6);
    check("fill_or", 32'(bus.or_res), 32'hF);

    // DONE ignores requests and holds results
    bus.req0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("done_no_gnt0", 32'(bus.gnt0), 32'd0);
      check("done_valid", 32'(bus.res_valid), 32'd1);
    end
    bus.req0 = 1'b0;
    check("done_busy", 32'(bus.busy), 32'd1);
    check("done_count", 32'(bus.count), 32'd3);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("clr2_count", 32'(bus.count), 32'd0);
    check("clr2_busy", 32'(bus.busy), 32'd0);
    check("clr2_valid", 32'(bus.res_valid), 32'd0);
    check("clr2_and_kept", 32'(bus.and_res), 32'h6);
    check("clr2_or_kept", 32'(bus.or_res), 32'hF);
    write_one(0, 4'h9);
    check("post_clr_count", 32'(bus.count), 32'd1);

    // clr during a requester-1 grant: write lost, last_id still moves to 1
    bus.req1 = 1'b1;
    bus.wdata1 = 4'hA;
    @(negedge clk);
    check("cg_gnt1", 32'(bus.gnt1), 32'd1);
    bus.req1 = 1'b0;
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("cg_gnt1_off", 32'(bus.gnt1), 32'd0);
    check("cg_count", 32'(bus.count), 32'd0);
    check("cg_state", 32'(dbg_state), 32'd0);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    @(negedge clk);
    check("cg_tie_gnt0", 32'(bus.gnt0), 32'd1);
    check("cg_tie_gnt1", 32'(bus.gnt1), 32'd0);

    // asynchronous reset in the middle of that grant, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_gnt0", 32'(bus.gnt0), 32'd0);
    check("ar_gnt1", 32'(bus.gnt1), 32'd0);
    check("ar_count", 32'(bus.count), 32'd0);
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_valid", 32'(bus.res_valid), 32'd0);
    check("ar_and", 32'(bus.and_res), 32'd0);
    check("ar_or", 32'(bus.or_res), 32'd0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // after reset last_id is 1 again, so requester 0 wins a tie
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    @(negedge clk);
    check("post_rst_tie_gnt0", 32'(bus.gnt0), 32'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected finish before 50000");
    $fatal(1);
  end
endmodule
